// File: rtl/seat_pkg.sv
// Shared types for the seat manager: seat states, command opcodes,
// response codes and the sweep FSM encoding.
package seat_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_AWAY     = 2'd2
    } seat_state_t;

    typedef enum logic [1:0] {
        OP_RESERVE = 2'd0,
        OP_AWAY    = 2'd1,
        OP_RETURN  = 2'd2,
        OP_RELEASE = 2'd3
    } seat_op_t;

    typedef enum logic [1:0] {
        RS_OK       = 2'd0,
        RS_CONFLICT = 2'd1,
        RS_BADSEAT  = 2'd2,
        RS_NOTOWNER = 2'd3
    } seat_status_t;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_SCAN = 1'b1
    } fsm_t;

endpackage

// File: rtl/seat_tick_gen.sv
// Time base for the seat manager: a prescaler that pulses once every
// TICK_DIV cycles and a wrapping time-unit counter advanced by that pulse.
module seat_tick_gen
    import seat_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int TIME_W   = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_tick,
    output logic [TIME_W-1:0] o_time
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [TIME_W-1:0] r_time;

    assign o_tick = (r_cnt == CNT_LAST);
    assign o_time = r_time;

    // Prescaler wraps at TICK_DIV-1; the time counter advances on each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_time <= '0;
        end else if (o_tick) begin
            r_cnt  <= '0;
            r_time <= r_time + TIME_W'(1);
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seat_manager.sv
// Multi-seat controller: front-desk commands over valid/ready plus a
// periodic sweep that evicts seats left AWAY past their limit.
module seat_manager
    import seat_pkg::*;
#(
    parameter int NUM_SEATS = 32,
    parameter int SEAT_W    = $clog2(NUM_SEATS),
    parameter int ID_W      = 32,
    parameter int TIME_W    = 11,
    parameter int TICK_DIV  = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [SEAT_W-1:0] cmd_seat,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [TIME_W-1:0] cfg_limit,
    output logic              rsp_valid,
    output logic [1:0]        rsp_status,
    output logic [1:0]        rsp_state,
    output logic              evt_valid,
    output logic [SEAT_W-1:0] evt_seat,
    output logic [ID_W-1:0]   evt_id,
    output logic [SEAT_W:0]   occupancy,
    output logic [TIME_W-1:0] time_out,
    output logic              tick_miss
);

    localparam int OCC_W = SEAT_W + 1;
    localparam logic [SEAT_W-1:0] IDX_LAST = SEAT_W'(NUM_SEATS - 1);

    logic              w_tick;
    logic [TIME_W-1:0] w_time;

    fsm_t              r_fsm;
    logic [SEAT_W-1:0] r_idx;
    logic              r_pend;
    logic              r_miss;

    seat_state_t       r_state [NUM_SEATS];
    logic [ID_W-1:0]   r_owner [NUM_SEATS];
    logic [TIME_W-1:0] r_timer [NUM_SEATS];

    logic              r_rsp_valid;
    seat_status_t      r_rsp_status;
    seat_state_t       r_rsp_state;
    logic              r_evt_valid;
    logic [SEAT_W-1:0] r_evt_seat;
    logic [ID_W-1:0]   r_evt_id;
    logic [OCC_W-1:0]  r_occ;

    logic              w_bad;
    logic [SEAT_W-1:0] w_idx;
    seat_op_t          w_op;
    seat_state_t       w_cur;
    seat_state_t       w_nxt;
    logic              w_match;
    seat_status_t      w_status;
    logic              w_inc;
    logic              w_dec;

    seat_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TIME_W   (TIME_W)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick),
        .o_time (w_time)
    );

    assign cmd_ready  = (r_fsm == FSM_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_rsp_status;
    assign rsp_state  = r_rsp_state;
    assign evt_valid  = r_evt_valid;
    assign evt_seat   = r_evt_seat;
    assign evt_id     = r_evt_id;
    assign occupancy  = r_occ;
    assign time_out   = w_time;
    assign tick_miss  = r_miss;

    // Decode the presented command against the target seat's current state.
    always_comb begin
        w_bad    = (int'(cmd_seat) >= NUM_SEATS);
        w_idx    = w_bad ? '0 : cmd_seat;
        w_op     = seat_op_t'(cmd_op);
        w_cur    = r_state[w_idx];
        w_match  = (r_owner[w_idx] == cmd_id);
        w_status = RS_OK;
        w_nxt    = w_cur;
        w_inc    = 1'b0;
        w_dec    = 1'b0;
        if (w_bad) begin
            w_status = RS_BADSEAT;
            w_nxt    = ST_EMPTY;
        end else begin
            unique case (w_op)
                OP_RESERVE: begin
                    if (w_cur == ST_EMPTY) begin
                        w_nxt = ST_OCCUPIED;
                        w_inc = 1'b1;
                    end else begin
                        w_status = RS_CONFLICT;
                    end
                end
                OP_AWAY: begin
                    if (w_cur != ST_OCCUPIED)
                        w_status = RS_CONFLICT;
                    else if (!w_match)
                        w_status = RS_NOTOWNER;
                    else
                        w_nxt = ST_AWAY;
                end
                OP_RETURN: begin
                    if (w_cur != ST_AWAY)
                        w_status = RS_CONFLICT;
                    else if (!w_match)
                        w_status = RS_NOTOWNER;
                    else
                        w_nxt = ST_OCCUPIED;
                end
                OP_RELEASE: begin
                    if (w_cur == ST_EMPTY) begin
                        w_status = RS_CONFLICT;
                    end else if (!w_match) begin
                        w_status = RS_NOTOWNER;
                    end else begin
                        w_nxt = ST_EMPTY;
                        w_dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // IDLE serves commands; SCAN visits one seat per cycle for eviction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= FSM_IDLE;
            r_idx        <= '0;
            r_pend       <= 1'b0;
            r_miss       <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= RS_OK;
            r_rsp_state  <= ST_EMPTY;
            r_evt_valid  <= 1'b0;
            r_evt_seat   <= '0;
            r_evt_id     <= '0;
            r_occ        <= '0;
            for (int i = 0; i < NUM_SEATS; i++) begin
                r_state[i] <= ST_EMPTY;
                r_owner[i] <= '0;
                r_timer[i] <= '0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            r_evt_valid <= 1'b0;
            if (w_tick && r_pend)
                r_miss <= 1'b1;
            unique case (r_fsm)
                FSM_IDLE: begin
                    if (cmd_valid) begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_status <= w_status;
                        r_rsp_state  <= w_nxt;
                        if (!w_bad) begin
                            r_state[w_idx] <= w_nxt;
                            if (w_status == RS_OK) begin
                                unique case (w_op)
                                    OP_RESERVE: r_owner[w_idx] <= cmd_id;
                                    OP_AWAY:    r_timer[w_idx] <= cfg_limit;
                                    OP_RELEASE: r_owner[w_idx] <= '0;
                                    default: ;
                                endcase
                            end
                        end
                        if (w_inc)
                            r_occ <= r_occ + OCC_W'(1);
                        else if (w_dec)
                            r_occ <= r_occ - OCC_W'(1);
                    end
                    if (w_tick || r_pend) begin
                        r_fsm  <= FSM_SCAN;
                        r_idx  <= '0;
                        r_pend <= 1'b0;
                    end
                end
                FSM_SCAN: begin
                    if (w_tick)
                        r_pend <= 1'b1;
                    if (r_state[r_idx] == ST_AWAY) begin
                        if (r_timer[r_idx] == '0) begin
                            r_state[r_idx] <= ST_EMPTY;
                            r_owner[r_idx] <= '0;
                            r_evt_valid    <= 1'b1;
                            r_evt_seat     <= r_idx;
                            r_evt_id       <= r_owner[r_idx];
                            r_occ          <= r_occ - OCC_W'(1);
                        end else begin
                            r_timer[r_idx] <= r_timer[r_idx] - TIME_W'(1);
                        end
                    end
                    if (r_idx == IDX_LAST)
                        r_fsm <= FSM_IDLE;
                    else
                        r_idx <= r_idx + SEAT_W'(1);
                end
                default: r_fsm <= FSM_IDLE;
            endcase
        end
    end

endmodule
